seq_alu_param: RTL and testbench

- Parametrised multi-cycle integer ALU. Next generation of the 8-bit serial-bus ALU, generalised to any WIDTH.
- Operands arrive one word per cycle on `inbus`. Results leave as two words on `outbus`, framed by `finish`.
- Supported operations: signed add, signed subtract, signed radix-2 Booth multiply, and unsigned non-restoring 2W/W divide.
- New relative to the 8-bit ALU: `busy` status, a W-bit overflow flag, divide error detection, and width-scalable iteration count.

---
 rtl/seq_alu_param.sv | 186 ++++++++++++++++++
 tb/tb_seq_alu_param.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_param.sv
// seq_alu_param: multi-cycle W-bit ALU (add, sub, Booth mul, non-restoring div).
// Operands stream in on inbus; results leave as two words framed by finish.
module seq_alu_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             finish,
  output logic             busy,
  output logic             ovf,
  output logic             err,
  output logic [3:0]       state,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] M
);
  localparam int W = WIDTH;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD_X = 4'd1;
  localparam logic [3:0] S_LOAD_A = 4'd2;
  localparam logic [3:0] S_LOAD_B = 4'd3;
  localparam logic [3:0] S_EXEC   = 4'd4;
  localparam logic [3:0] S_CORR   = 4'd5;
  localparam logic [3:0] S_OUT_HI = 4'd6;
  localparam logic [3:0] S_OUT_LO = 4'd7;

  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  logic [3:0]       r_state;
  logic [3:0]       w_nxt;
  logic [W:0]       r_a;
  logic [W-1:0]     r_q;
  logic [W-1:0]     r_m;
  logic             r_qm1;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_ovf;
  logic             r_err;

  logic [W:0]   w_msx;
  logic [W:0]   w_mzx;
  logic [W:0]   w_sum;
  logic [W:0]   w_bacc;
  logic [W:0]   w_dsh;
  logic [W:0]   w_dacc;
  logic [W:0]   w_a_ex;
  logic [W-1:0] w_q_ex;
  logic         w_qm1_ex;
  logic         w_isdiv;
  logic         w_dz;
  logic         w_last;

  assign w_isdiv = (r_op == OP_DIV);
  assign w_last  = (r_cnt == LAST);
  // divisor zero or quotient would not fit in W bits
  assign w_dz    = (inbus == '0) || (r_a >= {1'b0, inbus});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_nxt = (op == OP_DIV) ? S_LOAD_X : S_LOAD_A;
      S_LOAD_X: w_nxt = S_LOAD_A;
      S_LOAD_A: w_nxt = S_LOAD_B;
      S_LOAD_B: w_nxt = (w_isdiv && w_dz) ? S_OUT_HI : S_EXEC;
      S_EXEC: begin
        if (!r_op[1])   w_nxt = S_OUT_HI;
        else if (w_last) w_nxt = w_isdiv ? S_CORR : S_OUT_HI;
      end
      S_CORR:   w_nxt = S_OUT_HI;
      S_OUT_HI: w_nxt = S_OUT_LO;
      S_OUT_LO: w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != S_IDLE);
    finish = (r_state == S_OUT_HI);
    outbus = '0;
    if (r_state == S_OUT_HI)
      outbus = w_isdiv ? r_q : r_a[W-1:0];
    else if (r_state == S_OUT_LO)
      outbus = w_isdiv ? r_a[W-1:0] : r_q;
  end

  always_comb begin
    w_msx = {r_m[W-1], r_m};
    w_mzx = {1'b0, r_m};
    if (r_op == OP_SUB) w_sum = w_msx - {r_q[W-1], r_q};
    else                w_sum = w_msx + {r_q[W-1], r_q};
    case ({r_q[0], r_qm1})
      2'b10:   w_bacc = r_a - w_msx;
      2'b01:   w_bacc = r_a + w_msx;
      default: w_bacc = r_a;
    endcase
    w_dsh  = {r_a[W-1:0], r_q[W-1]};
    w_dacc = r_a[W] ? (w_dsh + w_mzx) : (w_dsh - w_mzx);
    w_a_ex   = {(W+1){w_sum[W]}};
    w_q_ex   = w_sum[W-1:0];
    w_qm1_ex = r_qm1;
    if (r_op == OP_MUL) begin
      w_a_ex   = {w_bacc[W], w_bacc[W:1]};
      w_q_ex   = {w_bacc[0], r_q[W-1:1]};
      w_qm1_ex = r_q[0];
    end else if (w_isdiv) begin
      w_a_ex = w_dacc;
      w_q_ex = {r_q[W-2:0], ~w_dacc[W]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_qm1 <= 1'b0;
      r_cnt <= '0;
      r_op  <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
          end
        end
        S_LOAD_X: r_a <= {1'b0, inbus};
        S_LOAD_A: begin
          if (w_isdiv) r_q <= inbus;
          else         r_m <= inbus;
        end
        S_LOAD_B: begin
          r_cnt <= '0;
          if (!w_isdiv) begin
            r_q   <= inbus;
            r_a   <= '0;
            r_qm1 <= 1'b0;
          end else begin
            r_m <= inbus;
            if (w_dz) begin
              r_err <= 1'b1;
              r_q   <= '1;
              r_a   <= {1'b0, r_q};
            end
          end
        end
        S_EXEC: begin
          r_a   <= w_a_ex;
          r_q   <= w_q_ex;
          r_qm1 <= w_qm1_ex;
          r_cnt <= r_cnt + CNT_W'(1);
          // fits in W signed bits only if every upper bit copies the low sign
          if (!w_isdiv && w_nxt == S_OUT_HI)
            r_ovf <= (w_a_ex != {(W+1){w_q_ex[W-1]}});
        end
        S_CORR: if (r_a[W]) r_a <= r_a + w_mzx;
        default: ;
      endcase
    end
  end

  assign state = r_state;
  assign A     = r_a[W-1:0];
  assign Q     = r_q;
  assign M     = r_m;
  assign ovf   = r_ovf;
  assign err   = r_err;
endmodule

// File: tb/tb_seq_alu_param.sv
// tb_seq_alu_param: directed and random operations on W=8 and W=16 instances,
// checked every cycle against an arithmetic reference model.
module tb_seq_alu_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, rst16, st8, st16;
  logic [1:0]  op;
  logic [15:0] inbus;

  logic [7:0]  o8_out, o8_a, o8_q, o8_m;
  logic        o8_fin, o8_busy, o8_ovf, o8_err;
  logic [3:0]  o8_st;
  logic [15:0] o16_out, o16_a, o16_q, o16_m;
  logic        o16_fin, o16_busy, o16_ovf, o16_err;
  logic [3:0]  o16_st;

  seq_alu_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start(st8), .op(op), .inbus(inbus[7:0]),
    .outbus(o8_out), .finish(o8_fin), .busy(o8_busy), .ovf(o8_ovf),
    .err(o8_err), .state(o8_st), .A(o8_a), .Q(o8_q), .M(o8_m)
  );

  seq_alu_param #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst16), .start(st16), .op(op), .inbus(inbus),
    .outbus(o16_out), .finish(o16_fin), .busy(o16_busy), .ovf(o16_ovf),
    .err(o16_err), .state(o16_st), .A(o16_a), .Q(o16_q), .M(o16_m)
  );

  int          sel = 0;
  logic [15:0] y_out;
  logic        y_fin, y_busy, y_ovf, y_err;

  always_comb begin
    if (sel == 1) begin
      y_out  = o16_out;
      y_fin  = o16_fin;
      y_busy = o16_busy;
      y_ovf  = o16_ovf;
      y_err  = o16_err;
    end else begin
      y_out  = {8'h00, o8_out};
      y_fin  = o8_fin;
      y_busy = o8_busy;
      y_ovf  = o8_ovf;
      y_err  = o8_err;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: plain signed/unsigned arithmetic on the operand values
  task automatic model(input int w, input int o, input longint a, input longint b,
                       input longint c, output longint hi, output longint lo,
                       output bit ov, output bit er, output int lat);
    longint m, half, sa, sb, r, dv;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - (longint'(1) << w) : a;
    sb   = (b >= half) ? b - (longint'(1) << w) : b;
    if (o < 3) begin
      if (o == 0)      r = sa + sb;
      else if (o == 1) r = sa - sb;
      else             r = sa * sb;
      hi  = (r >>> w) & m;
      lo  = r & m;
      ov  = (r < -half) || (r > half - 1);
      er  = 1'b0;
      lat = (o == 2) ? 2 + w : 3;
    end else begin
      ov = 1'b0;
      if (c == 0 || a >= c) begin
        er  = 1'b1;
        hi  = m;
        lo  = b;
        lat = 3;
      end else begin
        dv  = (a << w) + b;
        hi  = dv / c;
        lo  = dv % c;
        er  = 1'b0;
        lat = -1;
      end
    end
  endtask

  longint n_hi, n_lo, e_hi, e_lo, obs_hi, obs_lo;
  bit     n_ovf, n_err, e_ovf, e_err;
  int     n_lat, e_lat, n_w, mw;
  int     arm_req = 0;
  int     arm_seen = 0;
  bit     armed = 0;
  bit     seen_hi = 0;
  int     k = 0;
  int     hi_k = 0;

  always @(negedge clk) begin
    if (arm_req != arm_seen) begin
      arm_seen = arm_req;
      armed    = 1'b1;
      seen_hi  = 1'b0;
      k        = 0;
      e_hi = n_hi; e_lo = n_lo; e_ovf = n_ovf; e_err = n_err;
      e_lat = n_lat; mw = n_w;
    end
    if (armed) begin
      if (y_fin && !seen_hi) begin
        if (e_lat >= 0) chk("latency", k, e_lat);
        chk("out_hi", y_out, e_hi);
        chk("ovf_hi", y_ovf, e_ovf);
        chk("err_hi", y_err, e_err);
        chk("busy_hi", y_busy, 1);
        obs_hi  = y_out;
        seen_hi = 1'b1;
        hi_k    = k;
      end else if (seen_hi && k == hi_k + 1) begin
        chk("out_lo", y_out, e_lo);
        chk("fin_lo", y_fin, 0);
        chk("ovf_lo", y_ovf, e_ovf);
        chk("err_lo", y_err, e_err);
        chk("busy_lo", y_busy, 1);
        obs_lo = y_out;
      end else if (seen_hi) begin
        chk("busy_end", y_busy, 0);
        chk("out_idle", y_out, 0);
        chk("ovf_hold", y_ovf, e_ovf);
        chk("err_hold", y_err, e_err);
        armed = 1'b0;
      end else begin
        chk("out_zero", y_out, 0);
        chk("flags_clr", {y_ovf, y_err}, 0);
        chk("busy_run", y_busy, 1);
        if (k > 3 * mw + 10) begin
          vectors++;
          miscompares++;
          $display("FAIL timeout: no finish after %0d cycles, required <= %0d", k, 3 * mw + 10);
          armed = 1'b0;
        end
      end
      k++;
    end
  end

  task automatic run(input int s, input int o, input longint a, input longint b,
                     input longint c, input bit poke);
    bit done;
    if (s != sel) begin
      for (int i = 0; i < 4 && armed; i++) @(posedge clk) #1;
      sel = s;
    end
    n_w = (s == 1) ? 16 : 8;
    model(n_w, o, a, b, c, n_hi, n_lo, n_ovf, n_err, n_lat);
    op = 2'(o);
    if (s == 1) st16 = 1'b1;
    else        st8  = 1'b1;
    @(posedge clk) #1;
    st8 = 1'b0;
    st16 = 1'b0;
    op = 2'($urandom);
    arm_req++;
    inbus = 16'(a);
    @(posedge clk) #1;
    inbus = 16'(b);
    if (o == 3) begin
      @(posedge clk) #1;
      inbus = 16'(c);
    end
    done = 1'b0;
    for (int i = 0; i < 120 && !done; i++) begin
      @(posedge clk) #1;
      inbus = 16'($urandom);
      if (poke) begin
        if (s == 1) st16 = (i == 0);
        else        st8  = (i == 0);
      end
      if (!y_busy) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL run_done: busy still 1 after 120 cycles, required 0");
      rst8 = 1'b1; rst16 = 1'b1;
      @(posedge clk) #1;
      rst8 = 1'b0; rst16 = 1'b0;
    end
  endtask

  function automatic longint pick(input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    case ($urandom_range(0, 7))
      0: return 0;
      1: return m;
      2: return longint'(1) << (w - 1);
      3: return (longint'(1) << (w - 1)) - 1;
      4: return 1;
      default: return longint'($urandom) & m;
    endcase
  endfunction

  initial begin
    int     s, w, o;
    longint a, b, c;
    rst8 = 1'b1; rst16 = 1'b1;
    st8 = 1'b0; st16 = 1'b0;
    op = 2'd0; inbus = 16'd0;
    #12;
    chk("rst_state", o8_st, 0);
    chk("rst_a", o8_a, 0);
    chk("rst_q", o8_q, 0);
    chk("rst_m", o8_m, 0);
    chk("rst_out", o8_out, 0);
    chk("rst_busy", o8_busy, 0);
    chk("rst_fin", o8_fin, 0);
    chk("rst_flags", {o8_ovf, o8_err}, 0);
    chk("rst16_state", o16_st, 0);
    chk("rst16_busy", o16_busy, 0);
    @(posedge clk) #1;
    rst8 = 1'b0; rst16 = 1'b0;

    run(0, 0, 'h80, 'h80, 0, 0);
    chk("lit_add_hi", obs_hi, 'hFF);
    chk("lit_add_lo", obs_lo, 'h00);
    run(0, 1, 'h64, 'h9C, 0, 0);
    chk("lit_sub_hi", obs_hi, 'h00);
    chk("lit_sub_lo", obs_lo, 'hC8);
    run(0, 0, 5, 7, 0, 0);
    chk("lit_add2_lo", obs_lo, 'h0C);
    run(0, 2, 'h80, 'h80, 0, 1);
    chk("lit_mul_hi", obs_hi, 'h40);
    chk("lit_mul_lo", obs_lo, 'h00);
    run(0, 3, 'h12, 'h34, 'h56, 0);
    chk("lit_div_q", obs_hi, 'h36);
    chk("lit_div_r", obs_lo, 'h10);
    run(0, 3, 'h12, 'h34, 'h00, 0);
    chk("lit_div0_hi", obs_hi, 'hFF);
    chk("lit_div0_lo", obs_lo, 'h34);
    run(1, 2, 300, 'hFF38, 0, 0);
    chk("lit_mul16_hi", obs_hi, 'hFFFF);
    chk("lit_mul16_lo", obs_lo, 'h15A0);

    st16 = 1'b1; op = 2'd2;
    @(posedge clk) #1;
    st16 = 1'b0; inbus = 16'd7;
    @(posedge clk) #1;
    inbus = 16'd9;
    @(posedge clk) #1;
    @(posedge clk) #1;
    chk("pre_rst_state", o16_st, 4);
    rst16 = 1'b1;
    @(negedge clk);
    chk("midrst_state", o16_st, 0);
    chk("midrst_a", o16_a, 0);
    chk("midrst_q", o16_q, 0);
    chk("midrst_m", o16_m, 0);
    chk("midrst_busy", o16_busy, 0);
    chk("midrst_out", o16_out, 0);
    @(posedge clk) #1;
    rst16 = 1'b0;
    run(1, 0, 1, 1, 0, 0);
    chk("lit_add16_hi", obs_hi, 'h0000);
    chk("lit_add16_lo", obs_lo, 'h0002);

    for (int t = 0; t < 240; t++) begin
      s = (t % 4 == 3) ? 1 : 0;
      w = (s == 1) ? 16 : 8;
      o = $urandom_range(0, 3);
      a = pick(w);
      b = pick(w);
      c = pick(w);
      if (o == 3 && c != 0 && $urandom_range(0, 3) != 0) a = a % c;
      run(s, o, a, b, c, 0);
    end
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
